button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 1000000, meaning the number of consecutive clock cycles a synchronized input must hold before being accepted (10 ms at 100 MHz); legal range 2..2^CNT_W-1.
REQ-002 SHALL have parameter CNT_W, default 20, meaning the debounce counter width in bits.
REQ-003 SHALL have port clock, input, 1 bit, meaning the single system clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, meaning an asynchronous, active-high reset, driven by the system reset synchronizer output.
REQ-005 SHALL have port btn_in, input, 1 bit, meaning the raw, asynchronous, bouncing push-button level (1 = pressed).
REQ-006 SHALL have port btn_level, output, 1 bit, meaning the debounced button level.
REQ-007 SHALL have port btn_pulse, output, 1 bit, meaning a one-cycle strobe on each accepted press.
REQ-008 SHALL have port btn_release, output, 1 bit, meaning a one-cycle strobe on each accepted release.
REQ-009 SHALL use one clock and an asynchronous, active-high reset only; there SHALL be no other clocks, enables or resets.

Function
REQ-010 SHALL pass btn_in through a two-flop synchronizer (s1, then btn_s) before any use; no logic SHALL read btn_in directly.
REQ-011 SHALL implement FSM states IDLE, WAIT_PRESS, PRESSED and WAIT_RELEASE, held in a registered state plus a CNT_W-bit counter cnt.
REQ-012 In IDLE, btn_s=1 SHALL move the FSM to WAIT_PRESS with cnt<=1; otherwise the FSM SHALL stay in IDLE with cnt<=0.
REQ-013 In WAIT_PRESS, btn_s=0 SHALL return the FSM to IDLE with cnt<=0 and no strobe.
REQ-014 In WAIT_PRESS, btn_s=1 with cnt<STABLE_CNT-1 SHALL increment cnt.
REQ-015 In WAIT_PRESS, btn_s=1 with cnt==STABLE_CNT-1 SHALL move the FSM to PRESSED, set btn_level<=1 and btn_pulse<=1, and set cnt<=0.
REQ-016 PRESSED and WAIT_RELEASE SHALL mirror REQ-012..015 with btn_s inverted; acceptance SHALL set btn_level<=0 and btn_release<=1.
REQ-017 btn_pulse and btn_release SHALL each be high for exactly one cycle per accepted transition, and SHALL never be high simultaneously.
REQ-018 All outputs SHALL be registered, with no combinational path from btn_in to any output.
REQ-019 Latency: with btn_in stable high before rising edge 1, btn_level and btn_pulse SHALL go high immediately after edge STABLE_CNT+2; release latency SHALL be identical.
REQ-020 Any interruption of the required stable run SHALL restart qualification from zero; cnt SHALL never exceed STABLE_CNT-1 and SHALL never wrap.
REQ-021 Unreachable state encodings SHALL recover to IDLE with btn_level<=0 and no strobe.

Reset
REQ-022 Asserting reset SHALL immediately, and asynchronously, force s1=0, btn_s=0, state=IDLE, cnt=0, btn_level=0, btn_pulse=0 and btn_release=0.
REQ-023 Reset asserted mid-qualification or while in PRESSED SHALL abandon the transition and produce no strobe during reset.
REQ-024 A button held across reset deassertion SHALL be re-qualified as a new press, giving one btn_pulse after STABLE_CNT+2 edges.

Verification (STABLE_CNT=4, CNT_W=3)
REQ-025 Clean press: btn_in 0->1 before edge 1, then held -> btn_level=1 and btn_pulse=1 for one cycle after edge 6; btn_pulse=0 after edge 7.
REQ-026 Bounce: btn_in high for 3 cycles, low for 1, then high -> no btn_pulse until 4 consecutive btn_s=1 samples; exactly one btn_pulse in total.
REQ-027 Clean release: from PRESSED, btn_in 1->0 held -> btn_level=0 and btn_release=1 for one cycle after 6 edges; btn_pulse stays 0.
REQ-028 Short glitch: a 1-cycle btn_in high pulse in IDLE -> btn_level, btn_pulse and btn_release stay 0 throughout.
REQ-029 Reset mid-operation: reset asserted at cnt=2 of WAIT_PRESS -> all outputs 0 without waiting for a clock edge; with btn_in held high, one btn_pulse arrives 6 edges after reset release.
REQ-030 Random soak: 10k cycles of random btn_in with run lengths 1..8 -> btn_pulse and btn_release strictly alternate, and btn_level equals the value of the last accepted strobe.

Source files
------------

// File: rtl/button_debounce.sv
// Push-button debouncer: two-flop synchronizer, then a four-state qualifier that accepts a
// new level only after STABLE_CNT consecutive agreeing samples, with registered press/release strobes.
module button_debounce #(
  parameter int STABLE_CNT = 1000000,
  parameter int CNT_W      = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_pulse,
  output logic btn_release
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             s1;
  logic             btn_s;
  logic             level_nxt;
  logic             pulse_nxt;
  logic             release_nxt;

  // btn_in is asynchronous; nothing downstream may look at it before these two flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1    <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      s1    <= btn_in;
      btn_s <= s1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_pulse   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      btn_level   <= level_nxt;
      btn_pulse   <= pulse_nxt;
      btn_release <= release_nxt;
    end
  end

  // The first disagreeing sample, taken in IDLE/PRESSED, already counts as sample one.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = WAIT_PRESS;
          cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_PRESS: begin
        if (!btn_s) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_nxt = WAIT_RELEASE;
          cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_RELEASE: begin
        if (btn_s) begin
          state_nxt = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    level_nxt   = btn_level;
    pulse_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      WAIT_PRESS: begin
        if (btn_s && (cnt == CNT_LAST)) begin
          level_nxt = 1'b1;
          pulse_nxt = 1'b1;
        end
      end
      WAIT_RELEASE: begin
        if (!btn_s && (cnt == CNT_LAST)) begin
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end
      end
      IDLE, PRESSED: begin
        level_nxt = btn_level;
      end
      default: begin
        level_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_debounce.sv
// Randomized scoreboard bench for button_debounce: a run-length reference model predicts
// strobes and level; a negedge monitor pops expected strobes as the DUT emits them.
module tb_button_debounce;

  localparam int STABLE_CNT = 4;
  localparam int CNT_W      = 3;

  logic clock   = 1'b0;
  logic reset   = 1'b0;
  logic btn_in  = 1'b0;
  logic btn_level;
  logic btn_pulse;
  logic btn_release;

  button_debounce #(
    .STABLE_CNT(STABLE_CNT),
    .CNT_W     (CNT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_pulse  (btn_pulse),
    .btn_release(btn_release)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit is_press;
    int cyc;
  } strobe_t;

  int      errors = 0;
  int      checks = 0;
  strobe_t expq[$];
  bit      delay_line[$];
  int      run = 0;
  bit      exp_level = 1'b0;
  int      cyc = 0;
  bit      sample;
  strobe_t mon_e;
  bit      last_was_press = 1'b0;
  int      npulse = 0;

  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  task automatic applyStimulus(input bit value, input int cycles);
    btn_in = value;
    repeat (cycles) @(negedge clock);
  endtask

  // Edges from now until the requested strobe shows up, capped so a dead DUT cannot hang the run.
  task automatic measureLatency(input bit press, output int edges);
    edges = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      edges++;
      if (press ? btn_pulse : btn_release) break;
    end
  endtask

  // Reference: a new level is accepted once the synchronized input (btn_in two edges old)
  // has disagreed with the accepted level for STABLE_CNT consecutive edges.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      delay_line.delete();
      delay_line.push_back(1'b0);
      delay_line.push_back(1'b0);
      run       = 0;
      exp_level = 1'b0;
    end else begin
      cyc++;
      sample = delay_line.pop_front();
      delay_line.push_back(btn_in);
      if (sample != exp_level) run++;
      else run = 0;
      if (run == STABLE_CNT) begin
        exp_level = sample;
        expq.push_back('{is_press: sample, cyc: cyc});
        run = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (reset) last_was_press = 1'b0;
    checkOutput("level", btn_level, exp_level);
    checkOutput("strobe_overlap", btn_pulse & btn_release, 0);
    if (btn_pulse || btn_release) begin
      if (btn_pulse) npulse++;
      checkOutput("strobe_pending", expq.size() > 0, 1);
      if (expq.size() > 0) begin
        mon_e = expq.pop_front();
        checkOutput("strobe_kind", btn_pulse, mon_e.is_press);
        checkOutput("strobe_cycle", cyc, mon_e.cyc);
      end
      checkOutput("strobe_alternate", btn_pulse, !last_was_press);
      last_was_press = btn_pulse;
    end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
      checkOutput("strobe_missing", btn_pulse | btn_release, 1);
      mon_e = expq.pop_front();
    end
    checkOutput("level_vs_last_strobe", btn_level, last_was_press);
  end

  initial begin
    int edges;
    int pulses_before;
    int total;
    int n;
    bit v;

    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("reset_level", btn_level, 0);
    checkOutput("reset_pulse", btn_pulse, 0);
    checkOutput("reset_release", btn_release, 0);
    reset = 1'b0;
    applyStimulus(1'b0, 4);

    // Clean press, then clean release.
    btn_in = 1'b1;
    measureLatency(1'b1, edges);
    checkOutput("press_latency", edges, STABLE_CNT + 2);
    checkOutput("press_level", btn_level, 1);
    @(posedge clock);
    #1 checkOutput("pulse_one_cycle", btn_pulse, 0);
    @(negedge clock);
    applyStimulus(1'b1, 4);
    btn_in = 1'b0;
    measureLatency(1'b0, edges);
    checkOutput("release_latency", edges, STABLE_CNT + 2);
    checkOutput("release_level", btn_level, 0);
    @(posedge clock);
    #1 checkOutput("release_one_cycle", btn_release, 0);
    @(negedge clock);
    applyStimulus(1'b0, 4);

    // Bounce: 3 high, 1 low, then steady high gives exactly one press.
    pulses_before = npulse;
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 1);
    applyStimulus(1'b1, 12);
    checkOutput("bounce_pulse_count", npulse - pulses_before, 1);
    applyStimulus(1'b0, 12);

    // Single-cycle glitch must not be accepted.
    pulses_before = npulse;
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 12);
    checkOutput("glitch_pulse_count", npulse - pulses_before, 0);
    checkOutput("glitch_level", btn_level, 0);

    // Reset mid-qualification, button held across reset release.
    btn_in = 1'b1;
    repeat (4) @(posedge clock);
    #2 reset = 1'b1;
    #1 checkOutput("midqual_reset_pulse", btn_pulse, 0);
    checkOutput("midqual_reset_level", btn_level, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    measureLatency(1'b1, edges);
    checkOutput("post_reset_latency", edges, STABLE_CNT + 2);
    @(negedge clock);
    applyStimulus(1'b1, 3);

    // Reset while pressed clears the level without a clock edge.
    @(posedge clock);
    #2 reset = 1'b1;
    #1 checkOutput("pressed_reset_level", btn_level, 0);
    checkOutput("pressed_reset_release", btn_release, 0);
    btn_in = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    applyStimulus(1'b0, 10);

    // Random soak with run lengths 1..8.
    total = 0;
    while (total < 10000) begin
      n = int'($urandom_range(1, 8));
      v = 1'($urandom_range(0, 1));
      applyStimulus(v, n);
      total += n;
    end
    applyStimulus(1'b0, 20);
    checkOutput("queue_drained", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
